// File: rtl/noc_vchannel_arbiter_if.sv
// Per-VC source side and shared link side of the virtual-channel arbiter.
// The arbiter uses the slave modport; the sources/sink environment uses master.
interface noc_vchannel_arbiter_if #(
  parameter int unsigned FLIT_WIDTH = 34,
  parameter int unsigned VCHANNELS  = 3
);
  logic [VCHANNELS-1:0][FLIT_WIDTH-1:0] in_flit;
  logic [VCHANNELS-1:0]                 in_last;
  logic [VCHANNELS-1:0]                 in_valid;
  logic [VCHANNELS-1:0]                 in_ready;
  logic [FLIT_WIDTH-1:0]                out_flit;
  logic                                 out_last;
  logic [VCHANNELS-1:0]                 out_valid;
  logic [VCHANNELS-1:0]                 out_ready;

  modport slave (
    input  in_flit, in_last, in_valid, out_ready,
    output in_ready, out_flit, out_last, out_valid
  );

  modport master (
    output in_flit, in_last, in_valid, out_ready,
    input  in_ready, out_flit, out_last, out_valid
  );
endinterface

// File: rtl/noc_vchannel_arbiter.sv
// Round-robin scheduler sharing one NoC link among VCHANNELS virtual channels,
// zero-latency flit mux, optional grant hold for a whole packet.
module noc_vchannel_arbiter #(
  parameter int unsigned FLIT_WIDTH  = 34,
  parameter int unsigned VCHANNELS   = 3,
  parameter bit          LOCK_PACKET = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  noc_vchannel_arbiter_if.slave vc_if
);

  localparam int unsigned VC_W = (VCHANNELS > 1) ? $clog2(VCHANNELS) : 1;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  state_e                 state_q;
  logic [VCHANNELS-1:0]   prio_q;
  logic [VC_W-1:0]        lock_vc_q;

  logic [VCHANNELS-1:0]   prio_d;
  logic [VCHANNELS-1:0]   elig_c;
  logic [VCHANNELS-1:0]   lock_mask_c;
  logic [VCHANNELS-1:0]   rot_c;
  logic [VCHANNELS-1:0]   first_c;
  logic [VCHANNELS-1:0]   grant_c;
  logic [2*VCHANNELS-1:0] elig_dbl_c;
  logic [2*VCHANNELS-1:0] grant_dbl_c;
  logic [VC_W-1:0]        grant_idx_c;
  int unsigned            prio_idx_c;
  logic                   xfer_c;
  logic                   prio_adv_c;

  // Binary position of the one-hot round-robin pointer.
  always_comb begin
    prio_idx_c = 0;
    for (int unsigned i = 0; i < VCHANNELS; i++) begin
      if (prio_q[i]) prio_idx_c = i;
    end
  end

  // Rotate so prio sits at bit 0, take the lowest set bit, rotate back.
  // Reset gates eligibility so the link stays quiet while rst_n is low.
  always_comb begin
    lock_mask_c = (state_q == ST_LOCKED) ? (VCHANNELS'(1) << lock_vc_q) : '1;
    elig_c      = vc_if.in_valid & vc_if.out_ready & lock_mask_c & {VCHANNELS{rst_n}};
    elig_dbl_c  = {elig_c, elig_c} >> prio_idx_c;
    rot_c       = elig_dbl_c[VCHANNELS-1:0];
    first_c     = rot_c & (~rot_c + VCHANNELS'(1));
    grant_dbl_c = {VCHANNELS'(0), first_c} << prio_idx_c;
    grant_c     = grant_dbl_c[VCHANNELS-1:0] | grant_dbl_c[2*VCHANNELS-1:VCHANNELS];
  end

  // Link mux, handshakes and pointer-advance decision.
  always_comb begin
    vc_if.out_flit  = '0;
    vc_if.out_last  = 1'b0;
    grant_idx_c     = '0;
    for (int unsigned i = 0; i < VCHANNELS; i++) begin
      if (grant_c[i]) begin
        vc_if.out_flit = vc_if.in_flit[i];
        vc_if.out_last = vc_if.in_last[i];
        grant_idx_c    = VC_W'(i);
      end
    end
    vc_if.out_valid = grant_c;
    vc_if.in_ready  = grant_c;
    xfer_c          = |grant_c;
    prio_adv_c      = xfer_c && (!LOCK_PACKET || vc_if.out_last);
    prio_d          = (grant_c << 1) | (grant_c >> (VCHANNELS - 1));
  end

  // Pointer and packet-lock state; only transfers move either of them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q    <= VCHANNELS'(1);
      state_q   <= ST_IDLE;
      lock_vc_q <= '0;
    end else begin
      if (prio_adv_c) prio_q <= prio_d;
      if (LOCK_PACKET && xfer_c) begin
        if (state_q == ST_IDLE) begin
          if (!vc_if.out_last) begin
            state_q   <= ST_LOCKED;
            lock_vc_q <= grant_idx_c;
          end
        end else if (vc_if.out_last) begin
          state_q <= ST_IDLE;
        end
      end
    end
  end

endmodule

// File: doc/noc_vchannel_arbiter.md
# noc_vchannel_arbiter

Round-robin scheduler that shares one physical NoC link among `VCHANNELS` virtual channels. It sits at each tile's NoC output, between the per-VC packet sources and the router input port. Every cycle it picks one VC whose source has a flit and whose downstream VC buffer can accept it, and forwards that flit with zero latency. An optional mode keeps the link on one VC from a packet's first flit to its last.

## Interface

Parameters:
- `FLIT_WIDTH`, 34 — flit width in bits; equals NoC data width plus type width (32 + 2).
- `VCHANNELS`, 3 — number of virtual channels; legal range 1..16.
- `LOCK_PACKET`, 0 — 0: arbitrate per flit; 1: hold the grant for a whole packet.

Ports:
- `clk` in 1 — clock.
- `rst_n` in 1 — reset, asynchronous, active-low.
- `in_flit` in `[VCHANNELS][FLIT_WIDTH]` — per-VC source flit.
- `in_last` in `[VCHANNELS]` — per-VC last-flit-of-packet marker.
- `in_valid` in `[VCHANNELS]` — per-VC flit valid.
- `in_ready` out `[VCHANNELS]` — per-VC accept; one-hot or zero.
- `out_flit` out `FLIT_WIDTH` — link flit.
- `out_last` out 1 — link last marker.
- `out_valid` out `[VCHANNELS]` — link valid, one-hot VC tag or zero.
- `out_ready` in `[VCHANNELS]` — downstream per-VC buffer can accept.

## Operation

State:
- `prio` — one-hot round-robin pointer; reset value is VC0.
- `locked` — 1 bit; reset value 0.
- `lock_vc` — `clog2(VCHANNELS)` bits; reset value 0.
- No other registers.

Eligibility:
- `elig[v] = in_valid[v] & out_ready[v]`.
- While `locked`, `elig` is additionally masked to `lock_vc` only.

Grant:
- `grant` = first set bit of `elig`, scanning upward from the `prio` position and wrapping modulo `VCHANNELS`.
- `grant` is one-hot, or zero when nothing is eligible.

Datapath (combinational):
- `out_valid = grant`.
- `in_ready = grant`.
- `out_flit` and `out_last` are the granted VC's `in_flit` and `in_last`.
- When `grant` is zero, `out_flit` and `out_last` are driven to 0.

Transfer:
- A transfer happens in any cycle where `grant != 0`. Source and sink handshake in that same cycle because `out_ready` is already folded into `elig`.

Pointer update:
- `LOCK_PACKET=0`: after a transfer on VC k, `prio <= one-hot(k+1 mod VCHANNELS)`. With no transfer, `prio` holds.
- `LOCK_PACKET=1`: `prio` advances as above only on a transfer with `out_last=1`.

Lock FSM (`LOCK_PACKET=1` only; otherwise `locked` stays 0):
- IDLE (`locked=0`): a transfer on VC k with `in_last=0` → LOCKED, `lock_vc <= k`. A transfer with `in_last=1` (single-flit packet) → stays IDLE.
- LOCKED: a transfer with `in_last=1` → IDLE. A transfer with `in_last=0`, or no transfer, → stays LOCKED.
- While LOCKED and `lock_vc` is not eligible (source empty or downstream full), `grant=0`. The link idles and no other VC may interleave.

Boundary conditions:
- `VCHANNELS=1`: `prio` is constant; the block degenerates to a pass-through gated by `in_valid[0] & out_ready[0]`.
- All VCs eligible: strict rotation; each VC gets at least 1 of every `VCHANNELS` transfers (per-flit mode) or packets (lock mode).
- `in_valid` may drop without a transfer; no source-side stability is required.
- Reset asserted mid-packet: `locked=0` and `prio=VC0` immediately (asynchronously). Any partially sent packet is the source's problem to discard or resend.

## Timing

- Zero-cycle latency: input to output is purely combinational through the mux.
- The `out_ready` to `in_ready` path is combinational; the downstream router must not derive `out_ready` from `out_valid`.
- Pointer and lock update on the rising `clk` edge after a transfer, and take effect in the next cycle's arbitration.
- Outputs during and just after reset, with inputs at 0: `out_valid=0`, `in_ready=0`, `out_flit=0`, `out_last=0`.
- Throughput: 1 flit per cycle whenever at least one VC is eligible.

## Test plan

1. Per-flit mode (`VCHANNELS=3`, `LOCK_PACKET=0`); after reset all `in_valid=1`, all `out_ready=1`, single-flit packets → `out_valid` sequence 001, 010, 100, 001, … with `in_ready` equal to `out_valid` every cycle.
2. Per-flit mode, `out_ready[1]=0`, all valid → grants alternate VC0 and VC2; `in_ready[1]` stays 0. Raise `out_ready[1]` after VC2 is granted → next grant is VC0, then VC1.
3. Per-flit mode, VC0 and VC2 each send a 4-flit packet at the same time → flits interleave VC0, VC2, VC0, VC2, …; `out_last` is 1 only on each packet's 4th flit.
4. `LOCK_PACKET=1`: VC2 starts a 4-flit packet while VC0 is valid → four consecutive VC2 grants, then VC0 in the cycle after VC2's last flit.
5. `LOCK_PACKET=1`: drop `out_ready[2]` for 3 cycles during flit 2 of a VC2 packet, with VC0 valid → `out_valid=0` for those 3 cycles, VC0 is never granted, and VC2 resumes afterwards.
6. `LOCK_PACKET=1`: pulse `rst_n` low during flit 3 of a VC1 packet, keeping VC0 and VC1 valid with `out_ready` high → during reset `out_valid=0`; first grant after release is VC0 (`prio` reset) and the lock is cleared.
